// File: rtl/synapse_weight_fetch.sv
// Presynaptic event FIFO plus weight-table lookup feeding the neuron spike_in port; 2 cycles push-to-valid.
// Backpressure: OUT holds while spike_in_ready=0, stall propagates to S1 then FIFO; evt_ready drops only when FIFO full.

module sync_fifo #(
  parameter int DAT_W = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_vld,
  input  logic [DAT_W-1:0]         push_dat,
  input  logic                     pop,
  output logic [DAT_W-1:0]         head_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DAT_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             push_en;
  logic             pop_en;

  assign full     = (cnt == CW'(DEPTH));
  assign empty    = (cnt == '0);
  assign push_en  = push_vld && !full;
  assign pop_en   = pop && !empty;
  assign head_dat = mem[rd_ptr];
  assign count    = cnt;

  // Storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_en) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({push_en, pop_en})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

module synapse_weight_fetch #(
  parameter int ID_WIDTH     = 16,
  parameter int WEIGHT_WIDTH = 8,
  parameter int SYN_ADDR_W   = 6,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cfg_we,
  input  logic [SYN_ADDR_W-1:0]         cfg_addr,
  input  logic [WEIGHT_WIDTH-1:0]       cfg_wdata,
  input  logic                          skip_zero,
  input  logic [ID_WIDTH-1:0]           evt_src_id,
  input  logic                          evt_valid,
  output logic                          evt_ready,
  output logic [ID_WIDTH-1:0]           input_neuron_id,
  output logic [WEIGHT_WIDTH-1:0]       synapse_weight,
  output logic                          spike_in_valid,
  input  logic                          spike_in_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [15:0]                   skip_count
);
  typedef struct packed {
    logic [ID_WIDTH-1:0]     id;
    logic [WEIGHT_WIDTH-1:0] wgt;
  } syn_evt_t;

  localparam int TBL_DEPTH = 2 ** SYN_ADDR_W;

  logic [WEIGHT_WIDTH-1:0] wtab [TBL_DEPTH];

  logic                  fifo_full;
  logic                  fifo_empty;
  logic [ID_WIDTH-1:0]   head_id;
  logic [SYN_ADDR_W-1:0] rd_addr;
  logic [WEIGHT_WIDTH-1:0] rd_wgt;
  logic                  pop;

  logic     s1_vld;
  syn_evt_t s1_dat;
  logic     s1_skip;
  logic     s1_adv;

  logic     out_vld;
  syn_evt_t out_dat;
  logic     out_free;

  assign evt_ready = !fifo_full;

  sync_fifo #(
    .DAT_W (ID_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_evt_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_vld (evt_valid),
    .push_dat (evt_src_id),
    .pop      (pop),
    .head_dat (head_id),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // Weight table survives reset so a flush does not force reprogramming.
  always_ff @(posedge clk) begin
    if (cfg_we) begin
      wtab[cfg_addr] <= cfg_wdata;
    end
  end

  assign rd_addr = head_id[SYN_ADDR_W-1:0];
  // Write-first: a same-cycle write to the popped address is what S1 sees.
  assign rd_wgt  = (cfg_we && (cfg_addr == rd_addr)) ? cfg_wdata : wtab[rd_addr];

  assign out_free = !out_vld || spike_in_ready;
  assign s1_skip  = s1_vld && skip_zero && (s1_dat.wgt == '0);
  assign s1_adv   = s1_vld && (s1_skip || out_free);
  assign pop      = !fifo_empty && (!s1_vld || s1_adv);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s1_dat <= '0;
    end else if (pop) begin
      s1_vld     <= 1'b1;
      s1_dat.id  <= head_id;
      s1_dat.wgt <= rd_wgt;
    end else if (s1_adv) begin
      s1_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld <= 1'b0;
      out_dat <= '0;
    end else if (s1_adv && !s1_skip) begin
      out_vld <= 1'b1;
      out_dat <= s1_dat;
    end else if (out_vld && spike_in_ready) begin
      out_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skip_count <= '0;
    end else if (s1_adv && s1_skip && (skip_count != 16'hFFFF)) begin
      skip_count <= skip_count + 16'd1;
    end
  end

  assign spike_in_valid  = out_vld;
  assign input_neuron_id = out_dat.id;
  assign synapse_weight  = out_dat.wgt;
endmodule

// File: tb/tb_synapse_weight_fetch.sv
// Directed bench for synapse_weight_fetch: scoreboard of expected (id, weight) popped at each output handshake.
module tb_synapse_weight_fetch;
  logic        clk;
  logic        rst_n;
  logic        cfg_we;
  logic [5:0]  cfg_addr;
  logic [7:0]  cfg_wdata;
  logic        skip_zero;
  logic [15:0] evt_src_id;
  logic        evt_valid;
  logic        evt_ready;
  logic [15:0] input_neuron_id;
  logic [7:0]  synapse_weight;
  logic        spike_in_valid;
  logic        spike_in_ready;
  logic [3:0]  fifo_count;
  logic [15:0] skip_count;

  typedef struct packed {
    logic [15:0] id;
    logic [7:0]  w;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] tb_wt [64];
  int         compares = 0;
  int         mism     = 0;

  synapse_weight_fetch #(
    .ID_WIDTH     (16),
    .WEIGHT_WIDTH (8),
    .SYN_ADDR_W   (6),
    .FIFO_DEPTH   (8)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cfg_we          (cfg_we),
    .cfg_addr        (cfg_addr),
    .cfg_wdata       (cfg_wdata),
    .skip_zero       (skip_zero),
    .evt_src_id      (evt_src_id),
    .evt_valid       (evt_valid),
    .evt_ready       (evt_ready),
    .input_neuron_id (input_neuron_id),
    .synapse_weight  (synapse_weight),
    .spike_in_valid  (spike_in_valid),
    .spike_in_ready  (spike_in_ready),
    .fifo_count      (fifo_count),
    .skip_count      (skip_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compares++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_w(input logic [5:0] a, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tb_wt[a] = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic push_evt(input logic [15:0] id, input logic [7:0] w, input bit fwd);
    int guard = 0;
    evt_src_id = id; evt_valid = 1'b1;
    while (!evt_ready && guard < 100) begin
      tick();
      guard++;
    end
    if (guard >= 100) chk("push_timeout", 32'(evt_ready), 32'd1);
    if (fwd) sb.push_back('{id, w});
    tick();
    evt_valid = 1'b0;
  endtask

  task automatic push_m(input logic [15:0] id);
    logic [7:0] w;
    w = tb_wt[id[5:0]];
    push_evt(id, w, !(skip_zero && (w == 8'd0)));
  endtask

  task automatic drain(input string tag);
    int guard = 0;
    while ((sb.size() != 0 || spike_in_valid) && guard < 200) begin
      tick();
      guard++;
    end
    chk(tag, 32'(sb.size()), 32'd0);
  endtask

  // Output monitor: checks each handshake against the scoreboard and hold-stability while stalled.
  initial begin
    logic        stall_q;
    logic [15:0] h_id;
    logic [7:0]  h_w;
    exp_t        e;
    stall_q = 1'b0; h_id = '0; h_w = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_q = 1'b0;
      end else begin
        if (stall_q) begin
          chk("hold_vld", 32'(spike_in_valid), 32'd1);
          chk("hold_id", 32'(input_neuron_id), 32'(h_id));
          chk("hold_w", 32'(synapse_weight), 32'(h_w));
        end
        if (spike_in_valid && spike_in_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_out", 32'(input_neuron_id), 32'hFFFF_FFFF);
          end else begin
            e = sb.pop_front();
            chk("out_id", 32'(input_neuron_id), 32'(e.id));
            chk("out_w", 32'(synapse_weight), 32'(e.w));
          end
        end
        stall_q = spike_in_valid && !spike_in_ready;
        h_id    = input_neuron_id;
        h_w     = synapse_weight;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", compares);
    $fatal(1, "watchdog");
  end

  initial begin
    int         acc;
    int         idx;
    int         cyc;
    int         maxc;
    logic [7:0] w_old;
    logic       take;

    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    skip_zero = 1'b0; evt_src_id = '0; evt_valid = 1'b0; spike_in_ready = 1'b1;
    #3;
    chk("rst_valid", 32'(spike_in_valid), 32'd0);
    chk("rst_id", 32'(input_neuron_id), 32'd0);
    chk("rst_w", 32'(synapse_weight), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_skip", 32'(skip_count), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    chk("rst_evt_ready", 32'(evt_ready), 32'd1);

    for (int i = 0; i < 64; i++) wr_w(6'(i), 8'(i * 3 + 7));
    wr_w(6'd0, 8'd100);
    wr_w(6'd1, 8'd150);
    wr_w(6'd2, 8'd200);
    wr_w(6'd5, 8'd0);

    // Table load and forward, with latency checks
    spike_in_ready = 1'b1;
    push_m(16'd0);
    chk("lat_v_n0", 32'(spike_in_valid), 32'd0);
    push_m(16'd1);
    chk("lat_v_n1", 32'(spike_in_valid), 32'd0);
    push_m(16'd2);
    chk("lat_v_n2", 32'(spike_in_valid), 32'd1);
    chk("lat_id0", 32'(input_neuron_id), 32'd0);
    chk("lat_w0", 32'(synapse_weight), 32'd100);
    tick();
    chk("lat_id1", 32'(input_neuron_id), 32'd1);
    chk("lat_w1", 32'(synapse_weight), 32'd150);
    tick();
    chk("lat_id2", 32'(input_neuron_id), 32'd2);
    chk("lat_w2", 32'(synapse_weight), 32'd200);
    tick();
    chk("lat_idle", 32'(spike_in_valid), 32'd0);
    drain("drain_fwd");

    // Back-pressure: 11 offered, 10 fit
    spike_in_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 11; i++) begin
      evt_src_id = 16'(20 + i);
      evt_valid  = 1'b1;
      if (!evt_ready) break;
      sb.push_back('{16'(20 + i), tb_wt[6'(20 + i)]});
      acc++;
      tick();
    end
    evt_valid = 1'b0;
    chk("bp_accepted", 32'(acc), 32'd10);
    chk("bp_evt_ready", 32'(evt_ready), 32'd0);
    chk("bp_count", 32'(fifo_count), 32'd8);
    chk("bp_out_vld", 32'(spike_in_valid), 32'd1);
    chk("bp_out_id", 32'(input_neuron_id), 32'd20);
    tick(); tick(); tick();
    chk("bp_hold_id", 32'(input_neuron_id), 32'd20);
    spike_in_ready = 1'b1;
    chk("bp_full_no_pass", 32'(evt_ready), 32'd0);
    drain("drain_bp");
    chk("bp_count_empty", 32'(fifo_count), 32'd0);

    // Zero-weight skip
    skip_zero = 1'b1;
    push_m(16'd5);
    push_m(16'd6);
    drain("drain_skip");
    tick(); tick();
    chk("skip_count1", 32'(skip_count), 32'd1);
    skip_zero = 1'b0;
    push_m(16'd5);
    drain("drain_noskip");
    chk("skip_count_keep", 32'(skip_count), 32'd1);

    // Write/read collision at pop, and OUT immune to later writes
    push_evt(16'd3, 8'd77, 1'b1);
    wr_w(6'd3, 8'd77);
    drain("drain_coll");
    spike_in_ready = 1'b0;
    w_old = tb_wt[4];
    push_m(16'd4);
    tick(); tick();
    chk("coll_out_vld", 32'(spike_in_valid), 32'd1);
    wr_w(6'd4, 8'd55);
    chk("coll_out_id", 32'(input_neuron_id), 32'd4);
    chk("coll_out_old_w", 32'(synapse_weight), 32'(w_old));
    spike_in_ready = 1'b1;
    drain("drain_coll_old");
    push_m(16'd4);
    drain("drain_coll_new");

    // Reset mid-stream
    spike_in_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_m(16'(40 + i));
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", 32'(spike_in_valid), 32'd0);
    chk("mrst_id", 32'(input_neuron_id), 32'd0);
    chk("mrst_count", 32'(fifo_count), 32'd0);
    chk("mrst_skip", 32'(skip_count), 32'd0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    spike_in_ready = 1'b1;
    tick();
    push_m(16'd1);
    drain("drain_mrst");

    // Wrap-around with ready toggling every cycle
    idx = 0; cyc = 0; maxc = 0;
    while ((idx < 24 || sb.size() != 0 || spike_in_valid) && cyc < 500) begin
      spike_in_ready = cyc[0];
      evt_valid      = (idx < 24);
      evt_src_id     = 16'(100 + idx);
      take           = evt_valid && evt_ready;
      if (take) sb.push_back('{16'(100 + idx), tb_wt[6'(100 + idx)]});
      tick();
      if (take) idx++;
      if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
      cyc++;
    end
    evt_valid = 1'b0;
    spike_in_ready = 1'b1;
    chk("wrap_pushed", 32'(idx), 32'd24);
    chk("wrap_sb_empty", 32'(sb.size()), 32'd0);
    chk("wrap_max_count", 32'(maxc <= 8), 32'd1);
    tick();
    chk("wrap_count_end", 32'(fifo_count), 32'd0);

    tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mism);
    $finish;
  end
endmodule
